// File: rtl/note_pkg.sv
// note_pkg: shared definitions for the note scroller.
//   colour_e - 2-bit per-lane colour code stored in song rows
//   state_e  - scroller FSM state encoding
//   song_len - length in rows of each built-in song (song 0 = no song)
package note_pkg;

  typedef enum logic [1:0] {
    COL_OFF = 2'd0,
    COL_R   = 2'd1,
    COL_G   = 2'd2,
    COL_B   = 2'd3
  } colour_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  function automatic int song_len(input int s);
    case (s)
      1:       song_len = 2;
      2:       song_len = 3;
      default: song_len = 0;
    endcase
  endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom: combinational song storage.
//   song     - song select (0 = no song, length 0)
//   row      - row index within the song
//   row_bits - LANES 2-bit colour codes, lane i at [2i+1:2i]
//   len      - number of rows in the selected song
module song_rom
  import note_pkg::*;
#(
  parameter int LANES     = 10,
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = 2,
  parameter int ROW_W     = 6,
  parameter int LEN_W     = 7
) (
  input  logic [SONG_W-1:0]  song,
  input  logic [ROW_W-1:0]   row,
  output logic [2*LANES-1:0] row_bits,
  output logic [LEN_W-1:0]   len
);

  function automatic colour_e lane_code(input int s, input int r, input int l);
    lane_code = COL_OFF;
    case (s)
      1: begin
        if (r == 0) begin
          if (l == 0)      lane_code = COL_R;
          else if (l == 1) lane_code = COL_G;
          else if (l == 2) lane_code = COL_B;
        end else if (r == 1) begin
          if (l == 3)      lane_code = COL_B;
          else if (l == 4) lane_code = COL_G;
          else if (l == 5) lane_code = COL_R;
        end
      end
      // diagonal green sweep across the lanes
      2: if (l == r) lane_code = COL_G;
      default: lane_code = COL_OFF;
    endcase
  endfunction

  always_comb begin
    row_bits = '0;
    len      = '0;
    if (int'(song) < NUM_SONGS) len = LEN_W'(song_len(int'(song)));
    for (int i = 0; i < LANES; i++) begin
      row_bits[2*i +: 2] = lane_code(int'(song), int'(row), i);
    end
  end

endmodule

// File: rtl/note_scroller.sv
// note_scroller: plays a stored song as scrolling colour rows.
//   clk, rst             - clock, async active-high reset
//   start, song          - begin playback of song (song 0 ignored)
//   loop_en              - wrap to row 0 instead of finishing
//   pause                - freeze the row timer
//   note_R/note_G/note_B - registered per-lane colour drive
//   offset, step_idx     - current pixel sub-step and row
//   busy, finish         - playback active, one-cycle end pulse
//
// state   | meaning
// IDLE    | waiting for start, colours off
// LOAD    | fetch row[step_idx], clear tick counter
// HOLD    | count TICK_DIV cycles (frozen by pause)
// ADVANCE | step offset / row, wrap or end
// FINISH  | one-cycle finish pulse, outputs cleared
module note_scroller
  import note_pkg::*;
#(
  parameter int LANES     = 10,
  parameter int STEPS_MAX = 64,
  parameter int TICK_DIV  = 100000,
  parameter int SUB_STEPS = 7,
  parameter int NUM_SONGS = 4,
  localparam int SONG_W   = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int OFF_W    = (SUB_STEPS > 1) ? $clog2(SUB_STEPS) : 1,
  localparam int STEP_W   = (STEPS_MAX > 1) ? $clog2(STEPS_MAX) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SONG_W-1:0] song,
  input  logic              loop_en,
  input  logic              pause,
  output logic [LANES-1:0]  note_R,
  output logic [LANES-1:0]  note_G,
  output logic [LANES-1:0]  note_B,
  output logic [OFF_W-1:0]  offset,
  output logic [STEP_W-1:0] step_idx,
  output logic              busy,
  output logic              finish
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LEN_W  = $clog2(STEPS_MAX + 1);

  state_e              state;
  logic                start_q;
  logic [SONG_W-1:0]   song_lat;
  logic [TICK_W-1:0]   tick;
  logic [2*LANES-1:0]  row_bits;
  logic [LEN_W-1:0]    len;
  logic [LANES-1:0]    r_d, g_d, b_d;
  logic                last_sub, last_row, tick_done;

  song_rom #(
    .LANES    (LANES),
    .NUM_SONGS(NUM_SONGS),
    .SONG_W   (SONG_W),
    .ROW_W    (STEP_W),
    .LEN_W    (LEN_W)
  ) u_rom (
    .song    (song_lat),
    .row     (step_idx),
    .row_bits(row_bits),
    .len     (len)
  );

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    for (int i = 0; i < LANES; i++) begin
      r_d[i] = (row_bits[2*i +: 2] == COL_R);
      g_d[i] = (row_bits[2*i +: 2] == COL_G);
      b_d[i] = (row_bits[2*i +: 2] == COL_B);
    end
  end

  assign last_sub  = (offset == OFF_W'(SUB_STEPS - 1));
  assign last_row  = ((LEN_W'(step_idx) + LEN_W'(1)) == len);
  assign tick_done = (tick == TICK_W'(TICK_DIV - 1));

  // start/song are captured one cycle before leaving IDLE, which gives the
  // start -> busy -> colours latency of one and two further edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      start_q  <= 1'b0;
      song_lat <= '0;
      tick     <= '0;
      offset   <= '0;
      step_idx <= '0;
      note_R   <= '0;
      note_G   <= '0;
      note_B   <= '0;
      busy     <= 1'b0;
      finish   <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_q) begin
            start_q <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_LOAD;
          end else if (start && (song != '0)) begin
            start_q  <= 1'b1;
            song_lat <= song;
          end
        end
        ST_LOAD: begin
          tick <= '0;
          if (len == '0) begin
            finish   <= 1'b1;
            step_idx <= '0;
            offset   <= '0;
            note_R   <= '0;
            note_G   <= '0;
            note_B   <= '0;
            state    <= ST_FINISH;
          end else begin
            note_R <= r_d;
            note_G <= g_d;
            note_B <= b_d;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!pause) begin
            if (tick_done) state <= ST_ADVANCE;
            else           tick  <= tick + TICK_W'(1);
          end
        end
        ST_ADVANCE: begin
          if (!last_sub) begin
            offset <= offset + OFF_W'(1);
            state  <= ST_LOAD;
          end else begin
            offset <= '0;
            if (!last_row) begin
              step_idx <= step_idx + STEP_W'(1);
              state    <= ST_LOAD;
            end else if (loop_en) begin
              step_idx <= '0;
              state    <= ST_LOAD;
            end else begin
              step_idx <= '0;
              finish   <= 1'b1;
              note_R   <= '0;
              note_G   <= '0;
              note_B   <= '0;
              state    <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_scroller.sv
// tb_note_scroller: self-checking bench for note_scroller.
// Expected row/finish events are queued when a song is started and
// popped by a negedge monitor when the DUT changes row, starts or ends.
module tb_note_scroller;

  localparam int LANES     = 10;
  localparam int STEPS_MAX = 64;
  localparam int TICK_DIV  = 4;
  localparam int SUB_STEPS = 7;
  localparam int NUM_SONGS = 4;
  localparam int PER       = (TICK_DIV + 2) * SUB_STEPS;

  logic             clk = 1'b0;
  logic             rst, start, loop_en, pause;
  logic [1:0]       song;
  logic [LANES-1:0] note_R, note_G, note_B;
  logic [2:0]       offset;
  logic [5:0]       step_idx;
  logic             busy, finish;

  int cyc = 0;
  int vec_cnt = 0;
  int miss_cnt = 0;

  note_scroller #(
    .LANES(LANES), .STEPS_MAX(STEPS_MAX), .TICK_DIV(TICK_DIV),
    .SUB_STEPS(SUB_STEPS), .NUM_SONGS(NUM_SONGS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .song(song), .loop_en(loop_en),
    .pause(pause), .note_R(note_R), .note_G(note_G), .note_B(note_B),
    .offset(offset), .step_idx(step_idx), .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    bit               fin;
    int               step;
    int               at;
    logic [LANES-1:0] r, g, b;
  } ev_t;

  ev_t sb[$];

  function automatic int song_len_m(input int s);
    if (s == 1) return 2;
    if (s == 2) return 3;
    return 0;
  endfunction

  function automatic void model_row(input int s, input int row,
                                    output logic [LANES-1:0] r,
                                    output logic [LANES-1:0] g,
                                    output logic [LANES-1:0] b);
    int codes[LANES];
    codes = '{default: 0};
    if (s == 1 && row == 0) begin codes[0] = 1; codes[1] = 2; codes[2] = 3; end
    if (s == 1 && row == 1) begin codes[3] = 3; codes[4] = 2; codes[5] = 1; end
    if (s == 2 && row < LANES) codes[row] = 2;
    r = '0; g = '0; b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (codes[i] == 1) r[i] = 1'b1;
      if (codes[i] == 2) g[i] = 1'b1;
      if (codes[i] == 3) b[i] = 1'b1;
    end
  endfunction

  task automatic push_ev(input bit fin, input int step, input int at, input int s);
    ev_t e;
    e.fin  = fin;
    e.step = step;
    e.at   = at;
    if (fin) begin
      e.r = '0; e.g = '0; e.b = '0;
    end else begin
      model_row(s, step, e.r, e.g, e.b);
    end
    sb.push_back(e);
  endtask

  // shift = extra cycles inserted during row 0 (pause)
  task automatic push_song(input int s, input int s0, input int shift);
    int len;
    len = song_len_m(s);
    push_ev(1'b0, 0, s0 + 1, s);
    if (len == 0) begin
      push_ev(1'b1, 0, s0 + 2, s);
    end else begin
      for (int r = 1; r < len; r++) push_ev(1'b0, r, s0 + 1 + PER * r + shift, s);
      push_ev(1'b1, 0, s0 + 1 + PER * len + shift, s);
    end
  endtask

  task automatic start_song(input int s, output int s0);
    @(negedge clk);
    start = 1'b1;
    song  = 2'(s);
    @(negedge clk);
    start = 1'b0;
    s0    = cyc;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // monitor
  logic       pb, pf;
  logic [5:0] ps;
  bit         col_pend, fin_pend;
  ev_t        cur;

  always @(negedge clk) begin
    if (rst) begin
      pb = 1'b0; pf = 1'b0; ps = '0; col_pend = 0; fin_pend = 0;
    end else begin
      if (col_pend) begin
        check("row_R", 32'(note_R), 32'(cur.r));
        check("row_G", 32'(note_G), 32'(cur.g));
        check("row_B", 32'(note_B), 32'(cur.b));
        check("row_busy", 32'(busy), 32'd1);
        col_pend = 0;
      end
      if (fin_pend) begin
        check("finish_width", 32'(finish), 32'd0);
        check("busy_after_finish", 32'(busy), 32'd0);
        fin_pend = 0;
      end
      if ((busy && !pb) || (step_idx != ps) || (finish && !pf)) begin
        if (sb.size() == 0) begin
          check("event_expected", 32'(sb.size()), 32'd1);
        end else begin
          cur = sb.pop_front();
          check("ev_cycle", 32'(cyc), 32'(cur.at));
          check("ev_step", 32'(step_idx), 32'(cur.step));
          check("ev_finish", 32'(finish), 32'(cur.fin));
          if (cur.fin) begin
            check("fin_colours", 32'(note_R | note_G | note_B), 32'd0);
            check("fin_offset", 32'(offset), 32'd0);
            fin_pend = 1;
          end else begin
            col_pend = 1;
          end
        end
      end
      pb = busy; ps = step_idx; pf = finish;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n;
    rst = 1'b1; start = 1'b0; song = '0; loop_en = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    check("rst_step", 32'(step_idx), 32'd0);
    check("rst_colours", 32'(note_R | note_G | note_B), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // plain playback, song 1
    start_song(1, s0);
    push_song(1, s0, 0);
    drain("song1_drain");

    // song 0 is ignored
    @(negedge clk);
    start = 1'b1; song = 2'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("song0_busy", 32'(busy), 32'd0);
    end

    // start while busy is ignored
    start_song(1, s0);
    push_song(1, s0, 0);
    wait_until(s0 + 5);
    start = 1'b1; song = 2'd2;
    @(negedge clk);
    start = 1'b0;
    drain("busy_start_drain");
    repeat (5) @(negedge clk);
    check("busy_start_idle", 32'(busy), 32'd0);

    // pause for 20 cycles in row 0, sub-step 1
    start_song(1, s0);
    push_song(1, s0, 20);
    wait_until(s0 + 9);
    pause = 1'b1;
    wait_until(s0 + 28);
    check("pause_offset", 32'(offset), 32'd1);
    wait_until(s0 + 29);
    pause = 1'b0;
    drain("pause_drain");

    // looping: wrap 1 -> 0 without finish, then stop at the next end
    loop_en = 1'b1;
    start_song(1, s0);
    push_ev(1'b0, 0, s0 + 1, 1);
    push_ev(1'b0, 1, s0 + 1 + PER, 1);
    push_ev(1'b0, 0, s0 + 1 + 2 * PER, 1);
    push_ev(1'b0, 1, s0 + 1 + 3 * PER, 1);
    push_ev(1'b1, 0, s0 + 1 + 4 * PER, 1);
    wait_until(s0 + 100);
    loop_en = 1'b0;
    drain("loop_drain");

    // three-row song and a zero-length song
    start_song(2, s0);
    push_song(2, s0, 0);
    drain("song2_drain");
    start_song(3, s0);
    push_song(3, s0, 0);
    drain("song3_drain");

    // reset mid-row
    start_song(1, s0);
    push_ev(1'b0, 0, s0 + 1, 1);
    n = 0;
    while (offset != 3'd3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_offset3", 32'(offset), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_offset", 32'(offset), 32'd0);
    check("mid_rst_colours", 32'(note_R | note_G | note_B), 32'd0);
    check("mid_rst_sb", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    start_song(1, s0);
    push_song(1, s0, 0);
    drain("replay_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
